// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - request/response bundle for the RV32I instruction encoder
// Purpose: groups the request side (in_*), the response side (out_*) and the
//          saturating error counter into one bundle.
// Ports:   master - request producer / word consumer (drives in_*, out_ready)
//          slave  - the encoder (drives in_ready, out_*, err_count)
interface instr_encoder_if #(
  parameter int XLEN      = 32,
  parameter int ERR_CNT_W = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [15:0]          in_decode;
  logic [4:0]           in_rd;
  logic [4:0]           in_rs1;
  logic [4:0]           in_rs2;
  logic [XLEN-1:0]      in_imm;
  logic [11:0]          in_csr_addr;
  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      out_instr;
  logic                 out_err;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output in_valid, in_decode, in_rd, in_rs1, in_rs2, in_imm, in_csr_addr, out_ready,
    input  in_ready, out_valid, out_instr, out_err, err_count
  );

  modport slave (
    input  in_valid, in_decode, in_rd, in_rs1, in_rs2, in_imm, in_csr_addr, out_ready,
    output in_ready, out_valid, out_instr, out_err, err_count
  );
endinterface

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - two-stage RV32I instruction encoder (decode vector -> instruction word)
// Purpose: S1 captures operands, instruction class/format and legality; S2 holds the
//          packed instruction word. Illegal or out-of-range requests yield word 0 with
//          out_err set and bump a saturating error counter when consumed.
// Ports:   clk - rising-edge clock
//          rst - synchronous active-high reset
//          bus - request/response bundle (slave side)
module instr_encoder #(
  parameter int XLEN      = 32,
  parameter int ERR_CNT_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  instr_encoder_if.slave bus
);
  typedef enum logic [3:0] {
    FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_CSR, FMT_RAW
  } fmt_e;

  logic [1:0] unit;
  logic [2:0] sub_unit;
  logic [3:0] sel;
  logic       is_imm;
  assign unit     = bus.in_decode[15:14];
  assign sub_unit = bus.in_decode[13:11];
  assign sel      = bus.in_decode[10:7];
  assign is_imm   = bus.in_decode[6];

  // calc_j carries no encoding information.
  logic unused_calc_j;
  assign unused_calc_j = bus.in_decode[0];

  // Immediate range flags (upper bits must be a pure sign extension).
  logic fit_i, fit_b, fit_j, fit_u, fit_u5;
  assign fit_i  = (bus.in_imm[31:11] == '0) || (bus.in_imm[31:11] == '1);
  assign fit_b  = ((bus.in_imm[31:12] == '0) || (bus.in_imm[31:12] == '1)) && !bus.in_imm[0];
  assign fit_j  = ((bus.in_imm[31:20] == '0) || (bus.in_imm[31:20] == '1)) && !bus.in_imm[0];
  assign fit_u  = (bus.in_imm[11:0] == '0);
  assign fit_u5 = (bus.in_imm[31:5] == '0);

  // S1 next-state: class decode. For fixed words (ecall/ebreak/fence) the whole
  // word travels in the immediate register.
  fmt_e            s1_fmt_d;
  logic [6:0]      s1_op_d, s1_f7_d;
  logic [2:0]      s1_f3_d;
  logic [4:0]      s1_rs1_d;
  logic [XLEN-1:0] s1_imm_d;
  logic            s1_err_d;

  always_comb begin
    s1_fmt_d = FMT_R;
    s1_op_d  = 7'h00;
    s1_f3_d  = 3'd0;
    s1_f7_d  = 7'h00;
    s1_rs1_d = bus.in_rs1;
    s1_imm_d = bus.in_imm;
    s1_err_d = 1'b0;
    if (bus.in_decode[3]) begin
      s1_fmt_d = FMT_RAW;
      s1_imm_d = 32'h0000_0073;
    end else if (bus.in_decode[2]) begin
      s1_fmt_d = FMT_RAW;
      s1_imm_d = 32'h0010_0073;
    end else if (bus.in_decode[4]) begin
      s1_fmt_d = FMT_RAW;
      s1_imm_d = is_imm ? 32'h0000_100F : {4'b0, bus.in_imm[7:0], 13'b0, 7'b0001111};
    end else if (bus.in_decode[5]) begin
      s1_fmt_d = FMT_CSR;
      s1_op_d  = 7'b1110011;
      s1_f3_d  = {is_imm, sel[1:0] + 2'd1};
      if (sel > 4'd2) s1_err_d = 1'b1;
      if (is_imm) begin
        s1_rs1_d = bus.in_imm[4:0];
        if (!fit_u5) s1_err_d = 1'b1;
      end
    end else begin
      case ({unit, sub_unit})
        5'b00_000: begin
          if (!is_imm) s1_err_d = 1'b1;
          case (sel)
            4'd0: begin s1_fmt_d = FMT_U; s1_op_d = 7'b0110111; if (!fit_u) s1_err_d = 1'b1; end
            4'd1: begin s1_fmt_d = FMT_U; s1_op_d = 7'b0010111; if (!fit_u) s1_err_d = 1'b1; end
            4'd2: begin s1_fmt_d = FMT_J; s1_op_d = 7'b1101111; if (!fit_j) s1_err_d = 1'b1; end
            4'd3: begin s1_fmt_d = FMT_I; s1_op_d = 7'b1100111; if (!fit_i) s1_err_d = 1'b1; end
            default: s1_err_d = 1'b1;
          endcase
        end
        5'b00_001: begin
          s1_fmt_d = FMT_B;
          s1_op_d  = 7'b1100011;
          if (!is_imm || !fit_b) s1_err_d = 1'b1;
          case (sel)
            4'd0: s1_f3_d = 3'd0;
            4'd1: s1_f3_d = 3'd1;
            4'd2: s1_f3_d = 3'd4;
            4'd3: s1_f3_d = 3'd5;
            4'd4: s1_f3_d = 3'd6;
            4'd5: s1_f3_d = 3'd7;
            default: s1_err_d = 1'b1;
          endcase
        end
        5'b00_010: begin
          if (is_imm && sel == 4'd0) begin
            s1_fmt_d = FMT_I;
            s1_op_d  = 7'b0010011;
            if (!fit_i) s1_err_d = 1'b1;
          end else if (!is_imm && sel <= 4'd1) begin
            s1_op_d = 7'b0110011;
            s1_f7_d = sel[0] ? 7'b0100000 : 7'b0000000;
          end else begin
            s1_err_d = 1'b1;
          end
        end
        5'b00_011: begin
          s1_fmt_d = is_imm ? FMT_I : FMT_R;
          s1_op_d  = is_imm ? 7'b0010011 : 7'b0110011;
          if (is_imm && !fit_i) s1_err_d = 1'b1;
          case (sel)
            4'd0: s1_f3_d = 3'd2;
            4'd1: s1_f3_d = 3'd3;
            4'd2: s1_f3_d = 3'd4;
            4'd3: s1_f3_d = 3'd6;
            4'd4: s1_f3_d = 3'd7;
            default: s1_err_d = 1'b1;
          endcase
        end
        5'b00_100: begin
          s1_fmt_d = is_imm ? FMT_SH : FMT_R;
          s1_op_d  = is_imm ? 7'b0010011 : 7'b0110011;
          if (is_imm && !fit_u5) s1_err_d = 1'b1;
          case (sel)
            4'd0: s1_f3_d = 3'd1;
            4'd1: s1_f3_d = 3'd5;
            4'd2: begin s1_f3_d = 3'd5; s1_f7_d = 7'b0100000; end
            default: s1_err_d = 1'b1;
          endcase
        end
        5'b01_000: begin
          s1_fmt_d = FMT_I;
          s1_op_d  = 7'b0000011;
          if (!is_imm || !fit_i) s1_err_d = 1'b1;
          case (sel)
            4'd0: s1_f3_d = 3'd0;
            4'd1: s1_f3_d = 3'd1;
            4'd2: s1_f3_d = 3'd2;
            4'd3: s1_f3_d = 3'd4;
            4'd4: s1_f3_d = 3'd5;
            default: s1_err_d = 1'b1;
          endcase
        end
        5'b01_001: begin
          s1_fmt_d = FMT_S;
          s1_op_d  = 7'b0100011;
          s1_f3_d  = sel[2:0];
          if (!is_imm || !fit_i || sel > 4'd2) s1_err_d = 1'b1;
        end
        default: s1_err_d = 1'b1;
      endcase
    end
    if (bus.in_decode[1]) s1_err_d = 1'b1;
  end

  // Pipeline control: S2 frees when consumed, S1 frees when S2 takes it.
  logic in_ready, s2_load;
  logic s1_valid_q, s2_valid_q;
  assign in_ready = !s1_valid_q || !s2_valid_q || bus.out_ready;
  assign s2_load  = s1_valid_q && (!s2_valid_q || bus.out_ready);

  fmt_e            s1_fmt_q;
  logic [6:0]      s1_op_q, s1_f7_q;
  logic [2:0]      s1_f3_q;
  logic [4:0]      s1_rd_q, s1_rs1_q, s1_rs2_q;
  logic [XLEN-1:0] s1_imm_q;
  logic [11:0]     s1_csr_q;
  logic            s1_err_q;

  always_ff @(posedge clk) begin
    if (in_ready && bus.in_valid) begin
      s1_fmt_q <= s1_fmt_d;
      s1_op_q  <= s1_op_d;
      s1_f3_q  <= s1_f3_d;
      s1_f7_q  <= s1_f7_d;
      s1_rd_q  <= bus.in_rd;
      s1_rs1_q <= s1_rs1_d;
      s1_rs2_q <= bus.in_rs2;
      s1_imm_q <= s1_imm_d;
      s1_csr_q <= bus.in_csr_addr;
      s1_err_q <= s1_err_d;
    end
  end

  logic [XLEN-1:0] s2_instr_d, s2_instr_q;
  logic            s2_err_q;

  always_comb begin
    s2_instr_d = '0;
    case (s1_fmt_q)
      FMT_R:   s2_instr_d = {s1_f7_q, s1_rs2_q, s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
      FMT_I:   s2_instr_d = {s1_imm_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
      FMT_SH:  s2_instr_d = {s1_f7_q, s1_imm_q[4:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
      FMT_S:   s2_instr_d = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_f3_q, s1_imm_q[4:0], s1_op_q};
      FMT_B:   s2_instr_d = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                             s1_imm_q[4:1], s1_imm_q[11], s1_op_q};
      FMT_U:   s2_instr_d = {s1_imm_q[31:12], s1_rd_q, s1_op_q};
      FMT_J:   s2_instr_d = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                             s1_rd_q, s1_op_q};
      FMT_CSR: s2_instr_d = {s1_csr_q, s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
      FMT_RAW: s2_instr_d = s1_imm_q;
      default: s2_instr_d = '0;
    endcase
    if (s1_err_q) s2_instr_d = '0;
  end

  logic [ERR_CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_instr_q <= '0;
      s2_err_q   <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      if (in_ready) s1_valid_q <= bus.in_valid;
      if (s2_load) begin
        s2_valid_q <= 1'b1;
        s2_instr_q <= s2_instr_d;
        s2_err_q   <= s1_err_q;
      end else if (bus.out_ready) begin
        s2_valid_q <= 1'b0;
      end
      if (s2_valid_q && bus.out_ready && s2_err_q && err_cnt_q != '1)
        err_cnt_q <= err_cnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_instr = s2_instr_q;
  assign bus.out_err   = s2_err_q;
  assign bus.err_count = err_cnt_q;
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Pipelined RV32I instruction encoder: the inverse of the core's 16-bit decode vector. It takes a decode vector plus register, immediate and CSR operands, and produces the 32-bit instruction word. Range and legality checks are applied to every word. It sits in the debug/program-buffer path, where it generates instruction words for injection into the fetch stream, and uses a valid/ready handshake on both sides.

## Interface
- XLEN, 32, instruction/immediate width; only 32 supported.
- ERR_CNT_W, 8, width of saturating error counter.

- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  encoder accepts request this cycle.
- in_decode  in  16  {unit[15:14], sub_unit[13:11], sel[10:7], imm[6], csr[5], fence[4], ecall[3], ebreak[2], illegal[1], calc_j[0]}.
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_imm  in  32  immediate value, sign-extended byte offset (CSR-immediate variants use in_imm[4:0] as uimm; FENCE uses in_imm[7:0] as pred/succ).
- in_csr_addr  in  12  CSR address.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  consumer accepts word.
- out_instr  out  32  encoded instruction; 32'h0 when out_err.
- out_err  out  1  request was illegal or immediate out of range.
- err_count  out  ERR_CNT_W  errors emitted since reset, saturating.

## Operation
- Class priority: ecall > ebreak > fence > csr > unit/sub_unit/sel. calc_j is ignored. illegal=1 forces an error.
- ecall→32'h00000073; ebreak→32'h00100073; fence, imm=0 → {4'b0, in_imm[7:0], 13'b0, 7'b0001111}; fence, imm=1 → 32'h0000100F.
- csr sel 0/1/2 → funct3 1/2/3; with imm=1 → funct3 5/6/7, rs1 field = in_imm[4:0]. sel>2 is an error.
- Unit 0, sub 0 (imm must be 1):
  - sel0 LUI (U, 0110111); sel1 AUIPC (U, 0010111); sel2 JAL (J, 1101111); sel3 JALR (I, funct3 0, 1100111).
- Unit 0, sub 1 (imm=1, B, 1100011): sel0–5 → funct3 0,1,4,5,6,7.
- Unit 0, sub 2: imm=1,sel0 ADDI; imm=0: sel0 ADD, sel1 SUB (funct7 0100000); any other combination is an error.
- Unit 0, sub 3: sel0–4 → funct3 2,3,4,6,7. imm=1 gives I-type 0010011; imm=0 gives R-type 0110011.
- Unit 0, sub 4: sel0 SLL(I) f3 1; sel1 SRL(I) f3 5; sel2 SRA(I) f3 5, funct7 0100000. Immediate forms place in_imm[4:0] in the shamt field.
- Unit 1, sub 0 (imm=1): loads, I-type 0000011, sel0–4 → funct3 0,1,2,4,5. Unit 1, sub 1 (imm=1): stores, S-type 0100011, sel0–2 → funct3 0,1,2.
- Unit 2 or 3 without csr set, any unlisted sel, sub_unit>4 in unit 0, sub_unit>1 in unit 1 → error.
- Immediate range checks (failure → error):
  - I and S: in_imm must fit 12-bit signed.
  - B: 13-bit signed, bit0=0.
  - J: 21-bit signed, bit0=0.
  - U: in_imm[11:0]=0.
  - Shift-immediate: in_imm[31:5]=0.
  - CSR-immediate: in_imm[31:5]=0.
- On error: out_instr=0, out_err=1. err_count increments by 1 when an errored word is accepted (out_valid&&out_ready), saturating at 2^ERR_CNT_W-1.

## Timing
- Two register stages, S1 and S2.
  - S1 captures inputs, class decode and range flags.
  - S2 holds packed out_instr/out_err.
- Latency: a request accepted at cycle N is presented at cycle N+2 when not stalled. Throughput is 1 per cycle.
- Handshake: a transfer occurs when valid&&ready on a rising edge.
  - out_valid/out_instr/out_err are stable while out_valid&&!out_ready.
  - in_ready = !s1_valid || !s2_valid || out_ready. in_ready has no combinational path from in_valid.
  - S2 loads from S1 when S2 is empty or out_ready=1. S1 loads when in_ready=1.
- With the pipeline full and out_ready=0, in_ready=0; no word is dropped, duplicated or reordered.
- Reset (at any time, including mid-transfer): both stages are invalidated and err_count=0.
  - Outputs read out_valid=0, out_instr=0, out_err=0 the cycle after rst is sampled.
  - in_ready=1 from the first cycle after rst deasserts.

## Test plan
- ADDI x1,x0,5: decode 16'h1040, rd=1, rs1=0, imm=5 → out_instr 32'h00500093 at N+2, out_err=0.
- BEQ x1,x2,+8: decode 16'h0841, rs1=1, rs2=2, imm=8 → 32'h00208463. Same request with imm=3 → out_instr=0, out_err=1, err_count=1.
- LUI x5,0x12345000 → 32'h123452B7. CSRRW x1,0x300,x2 (csr=1, sel0) → 32'h300110F3. ebreak bit → 32'h00100073.
- Backpressure: send 4 back-to-back requests with out_ready=0 for 3 cycles → in_ready falls after 2 are held; all 4 words emerge in order, unchanged.
- Saturation (ERR_CNT_W=2): 5 illegal requests → err_count 1,2,3,3,3.
- Assert rst mid-stream with both stages valid → next cycle out_valid=0, err_count=0; a following request encodes correctly.
